// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: launches KeyExpansion, caches the 11 round keys
// and replays them in forward (encrypt) or reverse (decrypt) order.
module aes_key_sched_ctrl #(
   parameter logic [1:0] KE_IDLE    = 2'd0,
   parameter int         KE_TIMEOUT = 32
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         key_valid_in,
   input  logic [127:0] key_in,
   output logic         key_ready_out,
   output logic         ke_start_out,
   output logic [127:0] ke_key_out,
   input  logic [127:0] ke_key_in,
   input  logic [1:0]   ke_state_in,
   input  logic         req_valid_in,
   input  logic         req_dec_in,
   output logic         req_ready_out,
   output logic         rk_valid_out,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_idx_out,
   output logic         rk_last_out,
   input  logic         rk_ready_in,
   output logic         key_loaded_out,
   output logic         err_out,
   output logic         busy_out
);

   localparam int TW = $clog2(KE_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_EXPAND,
      S_STREAM
   } state_t;

   state_t         state_q, state_d;
   logic [127:0]   key_q, key_d;
   logic           loaded_q, loaded_d;
   logic           err_q, err_d;
   logic           dec_q, dec_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [3:0]     idx_q, idx_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic [127:0]   cache_q [0:10];
   logic           cache_we;
   logic           is_last;
   logic           cap_done;
   logic           in_stream;

   assign is_last   = dec_q ? (idx_q == 4'd0) : (idx_q == 4'd10);
   assign in_stream = (state_q == S_STREAM);

   always_comb begin
      state_d  = state_q;
      key_d    = key_q;
      loaded_d = loaded_q;
      err_d    = err_q;
      dec_d    = dec_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      tmo_d    = tmo_q;
      cache_we = 1'b0;
      cap_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A pending key always wins over a stream request.
            if (key_valid_in) begin
               key_d    = key_in;
               loaded_d = 1'b0;
               err_d    = 1'b0;
               state_d  = S_START;
            end else if (req_valid_in && loaded_q) begin
               dec_d   = req_dec_in;
               idx_d   = req_dec_in ? 4'd10 : 4'd0;
               state_d = S_STREAM;
            end
         end
         S_START: begin
            cnt_d   = 4'd0;
            tmo_d   = '0;
            state_d = S_EXPAND;
         end
         S_EXPAND: begin
            tmo_d = tmo_q + 1'b1;
            if (ke_state_in != KE_IDLE) begin
               cache_we = 1'b1;
               cnt_d    = cnt_q + 4'd1;
               if (cnt_q == 4'd10) begin
                  cap_done = 1'b1;
                  loaded_d = 1'b1;
                  state_d  = S_IDLE;
               end
            end
            // Completion on the final allowed cycle takes precedence over the timeout.
            if (!cap_done && (tmo_d == TW'(KE_TIMEOUT))) begin
               err_d    = 1'b1;
               loaded_d = 1'b0;
               state_d  = S_IDLE;
            end
         end
         S_STREAM: begin
            if (rk_ready_in) begin
               if (is_last) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d = dec_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q  <= S_IDLE;
         key_q    <= '0;
         loaded_q <= 1'b0;
         err_q    <= 1'b0;
         dec_q    <= 1'b0;
         cnt_q    <= 4'd0;
         idx_q    <= 4'd0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         key_q    <= key_d;
         loaded_q <= loaded_d;
         err_q    <= err_d;
         dec_q    <= dec_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         tmo_q    <= tmo_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (cache_we) begin
         cache_q[cnt_q] <= ke_key_in;
      end
   end

   // Ready outputs are gated by RST so every output reads 0 while reset is held.
   assign key_ready_out  = RST && (state_q == S_IDLE);
   assign req_ready_out  = RST && (state_q == S_IDLE) && loaded_q && !key_valid_in;
   assign ke_start_out   = (state_q == S_START);
   assign ke_key_out     = key_q;
   assign busy_out       = (state_q != S_IDLE);
   assign key_loaded_out = loaded_q;
   assign err_out        = err_q;
   assign rk_valid_out   = in_stream;
   assign rk_out         = in_stream ? cache_q[idx_q] : '0;
   assign rk_idx_out     = in_stream ? idx_q : 4'd0;
   assign rk_last_out    = in_stream && is_last;

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
Controller and round-key cache for the AES-128 KeyExpansion unit. It accepts a cipher key over a valid/ready handshake and starts KeyExpansion. It captures the 11 round keys into an internal 11x128 store as they stream out. It then replays them to the round datapath: forward order (0..10) for encryption, reverse order (10..0) for decryption. Repeat requests under the same key do not re-run the expansion.

Parameters:
KE_IDLE, 2'd0, KeyExpansion state_out encoding for IDLE
KE_TIMEOUT, 32, maximum cycles from ke_start_out to the 11th capture before an error is flagged

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-low
key_valid_in  in  1  new cipher key offered
key_in  in  128  cipher key, word 0 in bits [127:96]
key_ready_out  out  1  key can be accepted
ke_start_out  out  1  one-cycle start pulse to KeyExpansion
ke_key_out  out  128  registered key driven to KeyExpansion key0..key3_in
ke_key_in  in  128  {key0_out,key1_out,key2_out,key3_out} from KeyExpansion
ke_state_in  in  2  KeyExpansion state_out
req_valid_in  in  1  round-key stream request
req_dec_in  in  1  0 = forward order, 1 = reverse order; sampled on acceptance
req_ready_out  out  1  request can be accepted
rk_valid_out  out  1  round key valid
rk_out  out  128  round key
rk_idx_out  out  4  round index of rk_out (0..10)
rk_last_out  out  1  final key of the stream
rk_ready_in  in  1  downstream accepts the round key
key_loaded_out  out  1  cache holds a complete schedule
err_out  out  1  sticky expansion timeout
busy_out  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: single clock CLK. RST is synchronous and active-low.
- Reset values: all outputs 0, FSM in IDLE, cache contents don't-care. Reset mid-operation aborts immediately and clears key_loaded_out and err_out.
- FSM states: IDLE, START, EXPAND, STREAM.
- key_ready_out = (state==IDLE). req_ready_out = (state==IDLE) && key_loaded_out && !key_valid_in.
- IDLE:
  - A key handshake (key_valid_in && key_ready_out) registers key_in into ke_key_out, clears key_loaded_out and err_out, then goes to START.
  - Otherwise a request handshake latches req_dec_in, then goes to STREAM.
  - If key_valid_in and req_valid_in are both high, the key wins and the request is not accepted.
- START: ke_start_out=1 for exactly one cycle, capture counter cnt=0, timeout counter cleared, then go to EXPAND.
- EXPAND:
  - Each cycle with ke_state_in != KE_IDLE: write ke_key_in to cache[cnt], then cnt++.
  - When cnt reaches 10 and is written: set key_loaded_out=1, go to IDLE.
  - The timeout counter increments every EXPAND cycle. On reaching KE_TIMEOUT without 11 captures: set err_out=1, key_loaded_out=0, go to IDLE.
  - Requests are refused until key_loaded_out is set again.
- STREAM:
  - Index starts at 0 (forward) or 10 (reverse).
  - rk_valid_out is asserted from the cycle after acceptance.
  - rk_out = cache[idx], rk_idx_out = idx.
  - rk_last_out=1 when idx==10 (forward) or idx==0 (reverse).
  - While rk_ready_in=0, rk_out, rk_idx_out and rk_last_out are held stable.
  - Each rk_valid_out && rk_ready_in handshake steps idx by +1 or -1.
  - The handshake with rk_last_out=1 deasserts rk_valid_out on the next cycle and returns to IDLE.
  - Minimum stream length is 11 cycles. A back-to-back request can be accepted in the first IDLE cycle.
- Index arithmetic is 4-bit. idx never leaves 0..10 and has no wrap past the ends.
- key_valid_in is ignored outside IDLE. key_ready_out=0 guarantees no new key during a stream or an expansion.

Test Plan:
- Key load: key 5468617473206D79204B756E67204675 from a KeyExpansion instance -> exactly one ke_start_out pulse; key_loaded_out=1 within KE_TIMEOUT cycles; cache[1]=E232FCF191129188B159E4E6D679A293 and cache[10]=28FDDEF86DA4244ACCC0A4FE3B316F26.
- Forward stream: req_dec_in=0 with rk_ready_in=1 -> 11 consecutive keys, idx 0..10, rk_last_out only on idx 10 (28FDDEF8...6F26), then back to IDLE.
- Reverse stream with stalls: req_dec_in=1 with rk_ready_in low every other cycle -> order 10..0; outputs held stable during stalls; last key is 5468...4675 at idx 0.
- Simultaneous key_valid_in and req_valid_in in IDLE: key accepted, request refused. A later request after reload streams the new schedule and no stale keys.
- Timeout: hold ke_state_in=KE_IDLE after start -> err_out=1 after 32 cycles, key_loaded_out=0, req_ready_out stays 0.
- Reset mid-stream: RST=0 at idx 5 -> next cycle rk_valid_out=0 and key_loaded_out=0. After release, a request is refused until a new key is loaded.
